// File: rtl/rbm_hidden_accum.sv
// rbm_hidden_accum: pre-activation accumulator for one RBM hidden neuron.
// Computes the bias plus the sum of the weights of all active visible units.
// The inputs arrive as a serial (v_bit, w_in) beat stream.
// The result is held, Q7.8, on sum_out and feeds the sigmoid unit directly.
// Optional build macro ACCUM_SATURATE_EN: each addition clamps to the signed
// range instead of wrapping. The sticky overflow flag exists in both builds.
module rbm_hidden_accum #(
  parameter int NUM_VISIBLE      = 16,
  parameter int WEIGHT_BITLENGTH = 16,
  parameter int SUM_BITLENGTH    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [WEIGHT_BITLENGTH-1:0] bias,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        v_bit,
  input  logic [WEIGHT_BITLENGTH-1:0] w_in,
  output logic [SUM_BITLENGTH-1:0]    sum_out,
  output logic                        sum_valid,
  input  logic                        sum_ready,
  output logic                        busy,
  output logic                        overflow
);

  localparam int CNT_W = $clog2(NUM_VISIBLE + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_VISIBLE - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                          state_q, state_d;
  logic signed [SUM_BITLENGTH-1:0] acc_q;
  logic signed [SUM_BITLENGTH-1:0] acc_next;
  logic signed [SUM_BITLENGTH:0]   sum_ext;
  logic signed [SUM_BITLENGTH-1:0] sum_q;
  logic [CNT_W-1:0]                cnt_q;
  logic                            ovf_q;
  logic                            beat;
  logic                            beat_ovf;

  // Exact sum is out of range when the two top bits of the widened result differ.
  function automatic logic range_exceeded(input logic signed [SUM_BITLENGTH:0] x);
    return x[SUM_BITLENGTH] ^ x[SUM_BITLENGTH-1];
  endfunction

  // Brings the widened sum back to SUM_BITLENGTH bits (clamp or wrap).
  function automatic logic signed [SUM_BITLENGTH-1:0] limit_sum(
    input logic signed [SUM_BITLENGTH:0] x
  );
`ifdef ACCUM_SATURATE_EN
    if (range_exceeded(x))
      return x[SUM_BITLENGTH] ? {1'b1, {(SUM_BITLENGTH-1){1'b0}}}
                              : {1'b0, {(SUM_BITLENGTH-1){1'b1}}};
    else
      return x[SUM_BITLENGTH-1:0];
`else
    return x[SUM_BITLENGTH-1:0];
`endif
  endfunction

  assign in_ready  = (state_q == ACCUM);
  assign sum_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum_out   = sum_q;
  assign overflow  = ovf_q;

  assign beat     = in_valid && in_ready;
  assign sum_ext  = (SUM_BITLENGTH+1)'(acc_q) + (SUM_BITLENGTH+1)'($signed(w_in));
  assign acc_next = limit_sum(sum_ext);
  assign beat_ovf = range_exceeded(sum_ext);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: start only in IDLE, leave ACCUM on the last beat, leave DONE on handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (beat && cnt_q == LAST_CNT) state_d = DONE;
      DONE:    if (sum_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Accumulator, beat counter, held result and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      acc_q <= SUM_BITLENGTH'($signed(bias));
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (beat) begin
      cnt_q <= cnt_q + 1'b1;
      if (v_bit) begin
        acc_q <= acc_next;
        if (beat_ovf) ovf_q <= 1'b1;
      end
      if (cnt_q == LAST_CNT) sum_q <= v_bit ? acc_next : acc_q;
    end
  end

endmodule

// File: doc/rbm_hidden_accum.md
Name: rbm_hidden_accum

Overview:
- Upstream stage of the sigmoid unit: computes the pre-activation sum for one RBM hidden neuron as bias plus the sum of the weights of all active (1) visible units.
- Consumes a serial stream of (visible bit, weight) beats over a valid/ready handshake.
- Presents a held 16-bit two's-complement Q7.8 sum (1.0 = 0x0100) that wires directly to the sigmoid `sum` input.

Parameters:
- NUM_VISIBLE, 16: number of visible units (beats) per accumulation; must be ≥1.
- WEIGHT_BITLENGTH, 16: weight and bias width, two's-complement Q7.8.
- SUM_BITLENGTH, 16: accumulator/output width; must equal WEIGHT_BITLENGTH and match the sigmoid input_bitlength.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins an accumulation; honoured only in IDLE.
- bias  in  WEIGHT_BITLENGTH  neuron bias; sampled on the accepted start cycle.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat ready; high only in ACCUM.
- v_bit  in  1  visible unit state for this beat.
- w_in  in  WEIGHT_BITLENGTH  weight for this beat.
- sum_out  out  SUM_BITLENGTH  accumulated pre-activation, to sigmoid.
- sum_valid  out  1  sum_out is final; held until accepted.
- sum_ready  in  1  downstream accepts the result.
- busy  out  1  high in ACCUM or DONE.

Behaviour:
- Reset (async, immediate): state=IDLE, acc=0, cnt=0, sum_out=0, sum_valid=0, in_ready=0, busy=0.
- Reset mid-operation aborts the run; partial sum is discarded, nothing is emitted.

State machine:
- IDLE:
  - start=1: acc←bias, cnt←0, go to ACCUM.
  - in_valid beats are ignored (in_ready=0).
- ACCUM:
  - in_ready=1.
  - Beat accepted when in_valid&in_ready.
  - On an accepted beat: if v_bit=1, acc←acc+w_in, else acc unchanged; cnt←cnt+1.
  - When the accepted beat has cnt==NUM_VISIBLE-1, go to DONE.
  - start is ignored in ACCUM.
- DONE:
  - sum_valid=1, sum_out=acc, in_ready=0.
  - On sum_valid&sum_ready, go to IDLE; sum_valid drops next cycle.
  - start is ignored until IDLE is reached.
  - start in the cycle after the handshake (now IDLE) is honoured.

Timing and latency:
- sum_valid rises the cycle after the last beat is accepted.
- Minimum run length: 1 (start) + NUM_VISIBLE + 1 cycles.
- in_valid gaps (bubbles) stall the count and leave acc unchanged.

Datapath rules:
- cnt width is clog2(NUM_VISIBLE+1).
- Addition is computed at SUM_BITLENGTH+1 bits with both operands sign-extended.
- Overflow handling is set by the Optional Feature below.
- sum_out is registered and equals acc; it is stable throughout DONE and holds its value in IDLE until the next DONE.

Optional Feature:
- Macro ACCUM_SATURATE_EN.
- Defined: each addition saturates. A positive overflow clamps to 0x7FFF; a negative overflow clamps to 0x8000. Subsequent beats continue from the clamped value.
- Undefined: addition wraps modulo 2^SUM_BITLENGTH with no clamp.
- An `overflow` output sticky flag exists in both builds:
  - Set on any beat whose exact sum exceeds range.
  - Cleared on accepted start and on rst.
  - Reset value 0.

Test Plan:
- Basic sum, NUM_VISIBLE=4: bias=0x0080, v=1,0,1,1, w=0x0100,0x7000,0xFF80,0x0040 -> sum_out=0x0140, sum_valid high exactly 1 cycle after the 4th beat, overflow=0.
- All-zero visible: bias=0xFE00, v=0000, any weights -> sum_out=0xFE00; a held-low sum_ready keeps sum_valid=1 and sum_out stable for 10 cycles.
- Overflow: bias=0x7F00, v=1111, w=0x0200 each:
  - With ACCUM_SATURATE_EN: sum_out=0x7FFF, overflow=1.
  - Without it: sum_out=0x8700, overflow=1.
- Negative saturation with ACCUM_SATURATE_EN: bias=0x8100, v=11, w=0xFE00 -> sum_out=0x8000.
- Bubbles and ignored start: insert 3-cycle in_valid gaps and pulse start during ACCUM -> result identical to the gapless run, cnt not reset.
- Async reset asserted mid-ACCUM (after 2 beats) -> outputs go to reset values immediately with no clock edge. A new start then yields the correct fresh sum.
